// File: rtl/csr_file_pkg.sv
// Shared CSR constants: address map, bus widths, misa value and mstatus bit positions.
package csr_file_pkg;

  localparam int CSR_REG_ADDR_BUS = 12;
  localparam int REG_BUS          = 32;

  localparam logic [CSR_REG_ADDR_BUS-1:0] CSR_MSTATUS   = 12'h300;
  localparam logic [CSR_REG_ADDR_BUS-1:0] CSR_MISA      = 12'h301;
  localparam logic [CSR_REG_ADDR_BUS-1:0] CSR_MIE       = 12'h304;
  localparam logic [CSR_REG_ADDR_BUS-1:0] CSR_MTVEC     = 12'h305;
  localparam logic [CSR_REG_ADDR_BUS-1:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [CSR_REG_ADDR_BUS-1:0] CSR_MEPC      = 12'h341;
  localparam logic [CSR_REG_ADDR_BUS-1:0] CSR_MCAUSE    = 12'h342;
  localparam logic [CSR_REG_ADDR_BUS-1:0] CSR_MTVAL     = 12'h343;
  localparam logic [CSR_REG_ADDR_BUS-1:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [CSR_REG_ADDR_BUS-1:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [CSR_REG_ADDR_BUS-1:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [CSR_REG_ADDR_BUS-1:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [CSR_REG_ADDR_BUS-1:0] CSR_CYCLE     = 12'hC00;
  localparam logic [CSR_REG_ADDR_BUS-1:0] CSR_INSTRET   = 12'hC02;
  localparam logic [CSR_REG_ADDR_BUS-1:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [CSR_REG_ADDR_BUS-1:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [CSR_REG_ADDR_BUS-1:0] CSR_MHARTID   = 12'hF14;

  localparam logic [REG_BUS-1:0] MISA_VAL = 32'h4000_0100;

  localparam int MSTATUS_MIE_BIT    = 3;
  localparam int MSTATUS_MPIE_BIT   = 7;
  localparam int MSTATUS_MPP_LO_BIT = 11;
  localparam int MSTATUS_MPP_HI_BIT = 12;

endpackage

// File: rtl/csr_counter64.sv
// Two-word free-running counter with per-half write ports; a write to either
// half replaces the increment for that cycle and never carries into the other half.
module csr_counter64 #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inc_en,
  input  logic           wr_lo,
  input  logic           wr_hi,
  input  logic [W-1:0]   wdata,
  output logic [2*W-1:0] count
);

  logic [2*W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (wr_lo) begin
      cnt_q[W-1:0] <= wdata;
    end else if (wr_hi) begin
      cnt_q[2*W-1:W] <= wdata;
    end else if (inc_en) begin
      cnt_q <= cnt_q + {{(2*W-1){1'b0}}, 1'b1};
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap state, combinational read port, trap/mret updates.
// Build option CSR_COUNTERS_EN adds mcycle/minstret and their user shadows.
module csr_file
  import csr_file_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter int              HART_ID     = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_csr_wr_en_i,
  input  logic [11:0]     wb_csr_addr_i,
  input  logic [XLEN-1:0] wb_csr_wdata_i,
  input  logic            wb_instret_inc_i,
  input  logic [11:0]     csr_raddr_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            trap_en_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_val_i,
  input  logic            mret_i,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            mstatus_mie_o
);

  logic            mie_bit_q;
  logic            mpie_bit_q;
  logic [XLEN-1:0] mie_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;

  // A trapping instruction is flushed, so its CSR write must not land.
  logic csr_we;
  assign csr_we = wb_csr_wr_en_i & ~trap_en_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_bit_q  <= 1'b0;
      mpie_bit_q <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else if (trap_en_i) begin
      mepc_q     <= {trap_pc_i[XLEN-1:1], 1'b0};
      mcause_q   <= trap_cause_i;
      mtval_q    <= trap_val_i;
      mpie_bit_q <= mie_bit_q;
      mie_bit_q  <= 1'b0;
    end else begin
      if (mret_i) begin
        mie_bit_q  <= mpie_bit_q;
        mpie_bit_q <= 1'b1;
      end else if (csr_we && wb_csr_addr_i == CSR_MSTATUS) begin
        mie_bit_q  <= wb_csr_wdata_i[MSTATUS_MIE_BIT];
        mpie_bit_q <= wb_csr_wdata_i[MSTATUS_MPIE_BIT];
      end
      if (csr_we) begin
        case (wb_csr_addr_i)
          CSR_MIE:      mie_q      <= wb_csr_wdata_i;
          CSR_MTVEC:    mtvec_q    <= {wb_csr_wdata_i[XLEN-1:2], 1'b0, wb_csr_wdata_i[0]};
          CSR_MSCRATCH: mscratch_q <= wb_csr_wdata_i;
          CSR_MEPC:     mepc_q     <= {wb_csr_wdata_i[XLEN-1:1], 1'b0};
          CSR_MCAUSE:   mcause_q   <= wb_csr_wdata_i;
          CSR_MTVAL:    mtval_q    <= wb_csr_wdata_i;
          default:      ;
        endcase
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [2*XLEN-1:0] mcycle_cnt;
  logic [2*XLEN-1:0] minstret_cnt;

  csr_counter64 #(.W(XLEN)) u_mcycle (
    .clk    (clk),
    .rst    (rst),
    .inc_en (1'b1),
    .wr_lo  (csr_we && wb_csr_addr_i == CSR_MCYCLE),
    .wr_hi  (csr_we && wb_csr_addr_i == CSR_MCYCLEH),
    .wdata  (wb_csr_wdata_i),
    .count  (mcycle_cnt)
  );

  csr_counter64 #(.W(XLEN)) u_minstret (
    .clk    (clk),
    .rst    (rst),
    .inc_en (wb_instret_inc_i),
    .wr_lo  (csr_we && wb_csr_addr_i == CSR_MINSTRET),
    .wr_hi  (csr_we && wb_csr_addr_i == CSR_MINSTRETH),
    .wdata  (wb_csr_wdata_i),
    .count  (minstret_cnt)
  );
`else
  logic unused_instret_inc;
  assign unused_instret_inc = wb_instret_inc_i;
`endif

  always_comb begin
    csr_rdata_o   = '0;
    csr_illegal_o = 1'b0;
    case (csr_raddr_i)
      CSR_MSTATUS: begin
        csr_rdata_o[MSTATUS_MIE_BIT]                       = mie_bit_q;
        csr_rdata_o[MSTATUS_MPIE_BIT]                      = mpie_bit_q;
        csr_rdata_o[MSTATUS_MPP_HI_BIT:MSTATUS_MPP_LO_BIT] = 2'b11;
      end
      CSR_MISA:     csr_rdata_o = XLEN'(MISA_VAL);
      CSR_MIE:      csr_rdata_o = mie_q;
      CSR_MTVEC:    csr_rdata_o = mtvec_q;
      CSR_MSCRATCH: csr_rdata_o = mscratch_q;
      CSR_MEPC:     csr_rdata_o = mepc_q;
      CSR_MCAUSE:   csr_rdata_o = mcause_q;
      CSR_MTVAL:    csr_rdata_o = mtval_q;
      CSR_MHARTID:  csr_rdata_o = XLEN'(HART_ID);
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE,   CSR_CYCLE:    csr_rdata_o = mcycle_cnt[XLEN-1:0];
      CSR_MCYCLEH,  CSR_CYCLEH:   csr_rdata_o = mcycle_cnt[2*XLEN-1:XLEN];
      CSR_MINSTRET, CSR_INSTRET:  csr_rdata_o = minstret_cnt[XLEN-1:0];
      CSR_MINSTRETH, CSR_INSTRETH: csr_rdata_o = minstret_cnt[2*XLEN-1:XLEN];
`else
      // Counter space stays legal but reads zero when counters are compiled out.
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
      CSR_CYCLE,  CSR_CYCLEH,  CSR_INSTRET,  CSR_INSTRETH: csr_rdata_o = '0;
`endif
      default:      csr_illegal_o = 1'b1;
    endcase
  end

  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;
  assign mstatus_mie_o = mie_bit_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: table of write/read vectors plus trap, mret,
// counter and asynchronous-reset sequences.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_csr_wr_en_i;
  logic [11:0] wb_csr_addr_i;
  logic [31:0] wb_csr_wdata_i;
  logic        wb_instret_inc_i;
  logic [11:0] csr_raddr_i;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        trap_en_i;
  logic [31:0] trap_pc_i;
  logic [31:0] trap_cause_i;
  logic [31:0] trap_val_i;
  logic        mret_i;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        mstatus_mie_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  csr_file #(
    .XLEN        (32),
    .MTVEC_RESET (32'h0000_1000),
    .HART_ID     (3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .wb_csr_wr_en_i   (wb_csr_wr_en_i),
    .wb_csr_addr_i    (wb_csr_addr_i),
    .wb_csr_wdata_i   (wb_csr_wdata_i),
    .wb_instret_inc_i (wb_instret_inc_i),
    .csr_raddr_i      (csr_raddr_i),
    .csr_rdata_o      (csr_rdata_o),
    .csr_illegal_o    (csr_illegal_o),
    .trap_en_i        (trap_en_i),
    .trap_pc_i        (trap_pc_i),
    .trap_cause_i     (trap_cause_i),
    .trap_val_i       (trap_val_i),
    .mret_i           (mret_i),
    .mtvec_o          (mtvec_o),
    .mepc_o           (mepc_o),
    .mstatus_mie_o    (mstatus_mie_o)
  );

  typedef struct {
    logic        do_wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wb_csr_wr_en_i = 1'b1;
    wb_csr_addr_i  = a;
    wb_csr_wdata_i = d;
    tick();
    wb_csr_wr_en_i = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [11:0] a,
                          input logic [31:0] exp, input logic exp_ill);
    csr_raddr_i = a;
    #1;
    check({name, " rdata"}, csr_rdata_o, exp);
    check({name, " illegal"}, {31'b0, csr_illegal_o}, {31'b0, exp_ill});
  endtask

  initial begin
    rst = 1'b1;
    wb_csr_wr_en_i = 1'b0; wb_csr_addr_i = '0; wb_csr_wdata_i = '0;
    wb_instret_inc_i = 1'b0; csr_raddr_i = '0;
    trap_en_i = 1'b0; trap_pc_i = '0; trap_cause_i = '0; trap_val_i = '0;
    mret_i = 1'b0;

    vecs[0]  = '{1'b0, 12'h305, 32'h0,         32'h0000_1000, 1'b0};
    vecs[1]  = '{1'b0, 12'hF14, 32'h0,         32'h0000_0003, 1'b0};
    vecs[2]  = '{1'b0, 12'h7C0, 32'h0,         32'h0000_0000, 1'b1};
    vecs[3]  = '{1'b0, 12'h301, 32'h0,         32'h4000_0100, 1'b0};
    vecs[4]  = '{1'b1, 12'h305, 32'h8000_0003, 32'h8000_0001, 1'b0};
    vecs[5]  = '{1'b1, 12'h301, 32'hFFFF_FFFF, 32'h4000_0100, 1'b0};
    vecs[6]  = '{1'b1, 12'h340, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0};
    vecs[7]  = '{1'b1, 12'h341, 32'h1234_5677, 32'h1234_5676, 1'b0};
    vecs[8]  = '{1'b1, 12'h300, 32'hFFFF_FFFF, 32'h0000_1888, 1'b0};
    vecs[9]  = '{1'b1, 12'h300, 32'h0000_0000, 32'h0000_1800, 1'b0};
    vecs[10] = '{1'b1, 12'h304, 32'h0000_0FFF, 32'h0000_0FFF, 1'b0};
    vecs[11] = '{1'b1, 12'h342, 32'h8000_000B, 32'h8000_000B, 1'b0};
    vecs[12] = '{1'b1, 12'h343, 32'h0000_DEAD, 32'h0000_DEAD, 1'b0};
    vecs[13] = '{1'b1, 12'h7C0, 32'h0000_0001, 32'h0000_0000, 1'b1};

    tick();
    check("rst mtvec_o", mtvec_o, 32'h0000_1000);
    check("rst mepc_o", mepc_o, 32'h0);
    check("rst mie_o", {31'b0, mstatus_mie_o}, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
      rd_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_ill);
      if (i == 4) check("mtvec_o after write", mtvec_o, 32'h8000_0001);
      if (i == 7) check("mepc_o after write", mepc_o, 32'h1234_5676);
    end

    // Trap with a colliding mscratch write, then mret.
    wr(12'h300, 32'h0000_0008);
    check("mie_o set", {31'b0, mstatus_mie_o}, 32'h1);
    trap_en_i = 1'b1; trap_pc_i = 32'h100; trap_cause_i = 32'd11; trap_val_i = 32'h55;
    wb_csr_wr_en_i = 1'b1; wb_csr_addr_i = 12'h340; wb_csr_wdata_i = 32'h5;
    tick();
    trap_en_i = 1'b0; wb_csr_wr_en_i = 1'b0;
    check("trap mepc_o", mepc_o, 32'h100);
    check("trap mie_o", {31'b0, mstatus_mie_o}, 32'h0);
    rd_check("trap mcause", 12'h342, 32'd11, 1'b0);
    rd_check("trap mtval", 12'h343, 32'h55, 1'b0);
    rd_check("trap mstatus", 12'h300, 32'h0000_1880, 1'b0);
    rd_check("trap mscratch", 12'h340, 32'hA5A5_A5A5, 1'b0);
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    check("mret mie_o", {31'b0, mstatus_mie_o}, 32'h1);
    rd_check("mret mstatus", 12'h300, 32'h0000_1888, 1'b0);

    trap_en_i = 1'b1; trap_pc_i = 32'h203; trap_cause_i = 32'h8000_0007;
    tick();
    trap_en_i = 1'b0;
    check("odd pc mepc_o", mepc_o, 32'h202);
    rd_check("trap2 mstatus", 12'h300, 32'h0000_1880, 1'b0);

`ifdef CSR_COUNTERS_EN
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'h0);
    rd_check("mcycle lo no inc", 12'hB00, 32'hFFFF_FFFF, 1'b0);
    rd_check("mcycle hi written", 12'hB80, 32'h0, 1'b0);
    tick();
    rd_check("mcycleh carry", 12'hB80, 32'h1, 1'b0);
    rd_check("mcycle wrap", 12'hB00, 32'h0, 1'b0);
    rd_check("cycleh shadow", 12'hC80, 32'h1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      wb_instret_inc_i = 1'b1;
      tick();
      wb_instret_inc_i = 1'b0;
      tick();
    end
    rd_check("minstret", 12'hB02, 32'h3, 1'b0);
    rd_check("minstreth", 12'hB82, 32'h0, 1'b0);
    rd_check("instret shadow", 12'hC02, 32'h3, 1'b0);
    wr(12'hC02, 32'h99);
    rd_check("instret ro", 12'hC02, 32'h3, 1'b0);
`else
    for (int k = 0; k < 3; k++) begin
      wb_instret_inc_i = 1'b1;
      tick();
      wb_instret_inc_i = 1'b0;
    end
    rd_check("no-cnt minstret", 12'hB02, 32'h0, 1'b0);
    rd_check("no-cnt cycleh", 12'hC80, 32'h0, 1'b0);
    wr(12'hB00, 32'h5);
    rd_check("no-cnt mcycle wr", 12'hB00, 32'h0, 1'b0);
`endif

    // Asynchronous reset mid-cycle with a write pending.
    wr(12'h304, 32'h0000_0888);
    wb_csr_wr_en_i = 1'b1; wb_csr_addr_i = 12'h340; wb_csr_wdata_i = 32'h7;
    rst = 1'b1;
    #1;
    check("arst mepc_o", mepc_o, 32'h0);
    check("arst mtvec_o", mtvec_o, 32'h0000_1000);
    check("arst mie_o", {31'b0, mstatus_mie_o}, 32'h0);
    rd_check("arst mie", 12'h304, 32'h0, 1'b0);
    rd_check("arst mepc", 12'h341, 32'h0, 1'b0);
    rd_check("arst mstatus", 12'h300, 32'h0000_1800, 1'b0);
    tick();
    wb_csr_wr_en_i = 1'b0;
    rst = 1'b0;
    tick();
    rd_check("post-rst mscratch", 12'h340, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file. It is the receiving end of the write-back stage's CSR write channel: it consumes the CSR write-enable, address and data, and the retire pulse.
- Provides a combinational read port to the decode/execute stages.
- Holds the machine trap-state registers and the cycle/instret counters.
- Exports mtvec, mepc and MIE to the trap/PC-redirect logic.

Parameters:
- XLEN, 32, data width of every CSR port and register.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
- HART_ID, 0, value returned by mhartid.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- wb_csr_wr_en_i  in  1  CSR write strobe from write-back
- wb_csr_addr_i  in  12  CSR write address
- wb_csr_wdata_i  in  XLEN  final CSR write value (set/clear already resolved upstream)
- wb_instret_inc_i  in  1  one instruction retired this cycle
- csr_raddr_i  in  12  read address from decode/execute
- csr_rdata_o  out  XLEN  read data, combinational
- csr_illegal_o  out  1  csr_raddr_i not implemented, combinational
- trap_en_i  in  1  take trap this cycle
- trap_pc_i  in  XLEN  faulting PC
- trap_cause_i  in  XLEN  mcause value
- trap_val_i  in  XLEN  mtval value
- mret_i  in  1  mret retiring this cycle
- mtvec_o  out  XLEN  current mtvec
- mepc_o  out  XLEN  current mepc
- mstatus_mie_o  out  1  global interrupt enable

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: MIE[3], MPIE[7]; MPP[12:11] reads 2'b11; other bits read 0.
  - misa 0x301: read-only, 32'h4000_0100.
  - mie 0x304, mscratch 0x340, mtval 0x343: full read/write.
  - mtvec 0x305: bit1 forced 0.
  - mepc 0x341: bit0 forced 0.
  - mcause 0x342: full read/write.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82: read/write.
  - cycle/cycleh 0xC00/0xC80, instret/instreth 0xC02/0xC82: read-only shadows.
  - mhartid 0xF14: reads HART_ID.
- Read port:
  - Pure combinational on registered state; no same-cycle write forwarding (hazards are resolved by the pipeline).
  - Unimplemented address: csr_rdata_o=0, csr_illegal_o=1.
- Write:
  - Takes effect at the clock edge when wb_csr_wr_en_i=1.
  - Writes to read-only or unimplemented addresses are silently ignored.
- Counters:
  - mcycle: 64-bit, increments every cycle, wraps to 0.
  - minstret: 64-bit, increments when wb_instret_inc_i=1, wraps to 0.
  - A CSR write to either half overrides the increment that cycle: the written half takes wdata, the other half holds (no carry).
- Trap (trap_en_i=1):
  - mepc<=trap_pc_i&~1, mcause<=trap_cause_i, mtval<=trap_val_i, MPIE<=MIE, MIE<=0.
  - Any same-cycle CSR write is discarded, because the instruction is flushed.
  - Counters still advance.
- mret (mret_i=1): MIE<=MPIE, MPIE<=1.
- Priority: trap > mret > CSR write.
- Reset values:
  - All registers 0, except mtvec=MTVEC_RESET.
  - Outputs under rst: mtvec_o=MTVEC_RESET, mepc_o=0, mstatus_mie_o=0.
  - Reset asserted mid-operation clears all state immediately, regardless of pending strobes.

Optional Feature:
- Macro: CSR_COUNTERS_EN.
- Defined: mcycle/minstret and their shadows are implemented as above.
- Undefined:
  - No counter flops.
  - Counter addresses read 0 with csr_illegal_o=0; writes are ignored.
  - wb_instret_inc_i is unused.

Decomposition:
- Shared define file: CSR address constants, the misa value, mstatus bit positions, and the CsrRegAddrBus / RegBus width macros.
- One natural sub-module: csr_counter64. It provides a 64-bit counter with an increment enable and independent lo/hi write ports; csr_file instantiates it twice.

Test Plan:
- Reset release, read 0x305 -> MTVEC_RESET; read 0xF14 -> HART_ID; read 0x7C0 -> rdata 0, illegal=1.
- Write 0x305 with 32'h8000_0003 -> mtvec_o=32'h8000_0001 the next cycle; write to 0x301 -> misa unchanged.
- Set MIE; trap_en_i with pc=32'h100, cause=11 and simultaneous write 0x340=5 -> mepc=0x100, mcause=11, MIE=0, MPIE=1, mscratch unchanged. Then mret_i -> MIE=1, MPIE=1.
- Write mcycle=32'hFFFF_FFFF, mcycleh=0 -> two cycles later mcycleh=1; the write cycle shows no increment.
- wb_instret_inc_i pulsed 3 times -> minstret=3; with CSR_COUNTERS_EN undefined, read 0xB02 -> 0, illegal=0.
- Assert rst mid-stream after nonzero mepc/mie -> all read 0 in the same cycle (async); mtvec_o=MTVEC_RESET.
